id_ex_stage: RTL and testbench

- ID/EX pipeline register with load-use hazard detection and write-back bypass capture.
- Latches decoded operands and control from the decode stage.
- Presents ex_rs1/ex_rs2/ex_rd and control to the EX stage and the operand forwarding logic.
- Inserts bubbles on load-use hazards and branch flushes, and freezes on downstream memory holds.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/id_ex_stage_load_use_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its hazard logic.
package pipe_pkg;

    localparam int PIPE_XLEN = 32;
    localparam int ALU_OP_W  = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] pc;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [PIPE_XLEN-1:0] rs1_data;
        logic [PIPE_XLEN-1:0] rs2_data;
        logic [PIPE_XLEN-1:0] imm;
        logic [ALU_OP_W-1:0]  alu_op;
        logic                 alu_src;
        logic                 reg_wr;
        logic                 mem_rd;
        logic                 mem_wr;
    } idex_t;

    // A bubble is all-zero so rd/rs fields can never match in forwarding and nothing writes.
    localparam idex_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_rd,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic       id_uses_rs1,
    input  logic [4:0] id_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rs2,
    output logic       load_use
);
    import pipe_pkg::*;

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_valid && ex_mem_rd && (ex_rd != REG_ZERO) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: bubbles on load-use and flush, freezes on hold, captures write-back data.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic [4:0]          id_rd,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_reg_wr,
    input  logic                id_mem_rd,
    input  logic                id_mem_wr,
    input  logic                wb_reg_wr,
    input  logic [4:0]          wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    input  logic                hold,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [4:0]          ex_rs1,
    output logic [4:0]          ex_rs2,
    output logic [4:0]          ex_rd,
    output logic [XLEN-1:0]     ex_rs1_data,
    output logic [XLEN-1:0]     ex_rs2_data,
    output logic [XLEN-1:0]     ex_imm,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_reg_wr,
    output logic                ex_mem_rd,
    output logic                ex_mem_wr,
    output logic                stall_if_id,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
);
    import pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    idex_t cur;
    idex_t loaded;
    logic  flush_pending;
    logic  flush_eff;
    logic  load_use;

    assign flush_eff = flush | flush_pending;

    load_use_detect u_load_use_detect (
        .ex_valid    (cur.valid),
        .ex_mem_rd   (cur.mem_rd),
        .ex_rd       (cur.rd),
        .id_valid    (id_valid),
        .id_uses_rs1 (id_uses_rs1),
        .id_rs1      (id_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    // A register written back this very cycle is not yet visible in the file read data.
    always_comb begin
        loaded          = BUBBLE;
        loaded.valid    = id_valid;
        loaded.pc       = id_pc;
        loaded.rs1      = id_rs1;
        loaded.rs2      = id_rs2;
        loaded.rd       = id_rd;
        loaded.rs1_data = (wb_reg_wr && (wb_rd != REG_ZERO) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
        loaded.rs2_data = (wb_reg_wr && (wb_rd != REG_ZERO) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
        loaded.imm      = id_imm;
        loaded.alu_op   = id_alu_op;
        loaded.alu_src  = id_alu_src;
        loaded.reg_wr   = id_reg_wr;
        loaded.mem_rd   = id_mem_rd;
        loaded.mem_wr   = id_mem_wr;
    end

    assign stall_if_id = hold | (load_use & ~flush_eff);

    // A flush arriving during hold is remembered and applied once the hold releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur           <= BUBBLE;
            flush_pending <= 1'b0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else if (hold) begin
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else if (flush_eff) begin
            cur           <= BUBBLE;
            flush_pending <= 1'b0;
            if (flush_count != CNT_MAX) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end else if (load_use) begin
            cur <= BUBBLE;
            if (stall_count != CNT_MAX) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end else begin
            cur <= loaded;
        end
    end

    assign ex_valid    = cur.valid;
    assign ex_pc       = cur.pc;
    assign ex_rs1      = cur.rs1;
    assign ex_rs2      = cur.rs2;
    assign ex_rd       = cur.rd;
    assign ex_rs1_data = cur.rs1_data;
    assign ex_rs2_data = cur.rs2_data;
    assign ex_imm      = cur.imm;
    assign ex_alu_op   = cur.alu_op;
    assign ex_alu_src  = cur.alu_src;
    assign ex_reg_wr   = cur.reg_wr;
    assign ex_mem_rd   = cur.mem_rd;
    assign ex_mem_wr   = cur.mem_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/hold/bypass vectors plus a random segment.
module tb_id_ex_stage;

    localparam int XLEN    = 32;
    localparam int AW      = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;
    localparam int BW      = 1 + XLEN + 15 + 3 * XLEN + AW + 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [AW-1:0]   id_alu_op;
    logic            id_alu_src, id_reg_wr, id_mem_rd, id_mem_wr;
    logic            wb_reg_wr;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush, hold;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [AW-1:0]   ex_alu_op;
    logic            ex_alu_src, ex_reg_wr, ex_mem_rd, ex_mem_wr;
    logic            stall_if_id;
    logic [CW-1:0]   stall_count, flush_count;

    id_ex_stage #(.XLEN(XLEN), .ALU_OP_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_wr(id_reg_wr),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_wr(ex_reg_wr),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .stall_if_id(stall_if_id), .stall_count(stall_count), .flush_count(flush_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] m_ex;
    bit            m_valid, m_mem_rd, m_fp;
    logic [4:0]    m_rd;
    int            m_stall, m_flush;
    logic [XLEN-1:0] pc_ctr = 32'h100;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] seen_value(input logic [4:0] r, input logic [XLEN-1:0] rf);
        if (wb_reg_wr && wb_rd != 5'd0 && wb_rd == r) return wb_data;
        return rf;
    endfunction

    function automatic bit model_hazard();
        return m_valid && m_mem_rd && (m_rd != 5'd0) && id_valid &&
               ((id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd));
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
                ex_alu_op, ex_alu_src, ex_reg_wr, ex_mem_rd, ex_mem_wr};
    endfunction

    task automatic model_bubble();
        m_ex = '0;
        m_valid = 1'b0;
        m_mem_rd = 1'b0;
        m_rd = 5'd0;
    endtask

    // Model: what EX must hold after each edge, pushed for the compare process.
    always @(posedge clk) begin
        if (rst) begin
            model_bubble();
            m_fp = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else if (hold) begin
            if (flush) m_fp = 1'b1;
        end else if (flush || m_fp) begin
            model_bubble();
            m_fp = 1'b0;
            if (m_flush < CNT_MAX) m_flush++;
        end else if (model_hazard()) begin
            model_bubble();
            if (m_stall < CNT_MAX) m_stall++;
        end else begin
            m_ex = {id_valid, id_pc, id_rs1, id_rs2, id_rd,
                    seen_value(id_rs1, id_rs1_data), seen_value(id_rs2, id_rs2_data), id_imm,
                    id_alu_op, id_alu_src, id_reg_wr, id_mem_rd, id_mem_wr};
            m_valid = id_valid;
            m_mem_rd = id_mem_rd;
            m_rd = id_rd;
        end
        exp_q.push_back(m_ex);
        chk_en = 1'b1;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL exp_q_empty: got 0 entries expected 1");
            end else begin
                check("ex_bundle", dut_bundle(), exp_q.pop_front());
            end
            check("stall_if_id", BW'(stall_if_id), BW'(hold | (model_hazard() & ~(flush | m_fp))));
            check("stall_count", BW'(stall_count), BW'(m_stall));
            check("flush_count", BW'(flush_count), BW'(m_flush));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = '0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_alu_op = '0; id_alu_src = 0; id_reg_wr = 0; id_mem_rd = 0; id_mem_wr = 0;
        wb_reg_wr = 0; wb_rd = 0; wb_data = '0; flush = 0; hold = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input bit u1, input bit u2,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input bit mr);
        id_valid = 1; id_pc = pc_ctr; pc_ctr = pc_ctr + 4;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = 32'h1000 + 32'(rd);
        id_alu_op = rd[3:0]; id_alu_src = rd[0]; id_reg_wr = 1; id_mem_rd = mr; id_mem_wr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        clear_inputs();
        rst = 1;
        tick();
        tick();
        check("reset_ex_valid", BW'(ex_valid), 0);
        check("reset_ex_pc", BW'(ex_pc), 0);
        check("reset_stall_count", BW'(stall_count), 0);
        rst = 0;

        // Normal load
        set_id(5'd3, 5'd4, 5'd5, 1, 1, 32'h11, 32'h22, 0);
        @(negedge clk); check("t1_stall", BW'(stall_if_id), 0);
        tick();
        check("t1_ex_valid", BW'(ex_valid), 1);
        check("t1_ex_rd", BW'(ex_rd), 5);
        check("t1_rs1_data", BW'(ex_rs1_data), 32'h11);

        // Load-use: lw x5 then add using x5
        set_id(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_id(5'd5, 5'd6, 5'd7, 1, 1, 32'h5, 32'h6, 0);
        @(negedge clk); check("t2_stall", BW'(stall_if_id), 1);
        tick();
        check("t2_bubble_valid", BW'(ex_valid), 0);
        check("t2_bubble_rd", BW'(ex_rd), 0);
        check("t2_bubble_rs1_data", BW'(ex_rs1_data), 0);
        check("t2_stall_count", BW'(stall_count), 1);
        @(negedge clk); check("t2_release_stall", BW'(stall_if_id), 0);
        tick();
        check("t2_add_valid", BW'(ex_valid), 1);
        check("t2_add_rd", BW'(ex_rd), 7);

        // Same pair but the add does not read rs1
        set_id(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_id(5'd5, 5'd6, 5'd8, 0, 0, 32'h5, 32'h6, 0);
        @(negedge clk); check("t2_nouse_stall", BW'(stall_if_id), 0);
        tick();
        check("t2_nouse_rd", BW'(ex_rd), 8);

        // Load targeting x0 never stalls
        set_id(5'd1, 5'd0, 5'd0, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_id(5'd0, 5'd6, 5'd9, 1, 1, 32'h0, 32'h6, 0);
        @(negedge clk); check("t2_x0_stall", BW'(stall_if_id), 0);
        tick();
        check("t2_x0_rd", BW'(ex_rd), 9);

        // Flush beats a simultaneous load-use
        set_id(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_id(5'd5, 5'd6, 5'd10, 1, 1, 32'h5, 32'h6, 0);
        flush = 1;
        @(negedge clk); check("t3_stall", BW'(stall_if_id), 0);
        tick();
        flush = 0;
        check("t3_ex_valid", BW'(ex_valid), 0);
        check("t3_flush_count", BW'(flush_count), 1);
        check("t3_stall_count", BW'(stall_count), 1);

        // Hold for three cycles with a flush in the first
        set_id(5'd2, 5'd3, 5'd11, 1, 1, 32'h2, 32'h3, 0);
        tick();
        check("t4_pre_rd", BW'(ex_rd), 11);
        set_id(5'd4, 5'd5, 5'd12, 1, 1, 32'h4, 32'h5, 0);
        hold = 1; flush = 1;
        @(negedge clk); check("t4_stall_c1", BW'(stall_if_id), 1);
        tick();
        flush = 0;
        check("t4_frozen_c1", BW'(ex_rd), 11);
        @(negedge clk); check("t4_stall_c2", BW'(stall_if_id), 1);
        tick();
        check("t4_frozen_c2", BW'(ex_rd), 11);
        tick();
        check("t4_frozen_c3", BW'(ex_valid), 1);
        hold = 0;
        @(negedge clk); check("t4_release_stall", BW'(stall_if_id), 0);
        tick();
        check("t4_bubble_valid", BW'(ex_valid), 0);
        check("t4_flush_count", BW'(flush_count), 2);
        tick();
        check("t4_after_rd", BW'(ex_rd), 12);

        // Write-back capture
        set_id(5'd3, 5'd7, 5'd13, 1, 1, 32'h55, 32'h0, 0);
        wb_reg_wr = 1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        tick();
        check("t5_rs2_bypass", BW'(ex_rs2_data), 32'hDEAD);
        check("t5_rs1_plain", BW'(ex_rs1_data), 32'h55);
        set_id(5'd3, 5'd0, 5'd14, 1, 1, 32'h66, 32'h0, 0);
        wb_rd = 5'd0;
        tick();
        check("t5_x0_no_bypass", BW'(ex_rs2_data), 0);
        check("t5_rs1_nomatch", BW'(ex_rs1_data), 32'h66);
        set_id(5'd3, 5'd0, 5'd14, 1, 1, 32'h66, 32'h0, 0);
        wb_rd = 5'd3;
        tick();
        check("t5_rs1_bypass", BW'(ex_rs1_data), 32'hDEAD);
        wb_reg_wr = 0;
        tick();
        check("t5_wr_off", BW'(ex_rs1_data), 32'h66);

        // Random traffic with a small register range so hazards are frequent
        for (int i = 0; i < 300; i++) begin
            id_valid = 1'($urandom_range(0, 1));
            id_pc = $urandom; id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_alu_op = AW'($urandom_range(0, 15)); id_alu_src = 1'($urandom_range(0, 1));
            id_reg_wr = 1'($urandom_range(0, 1)); id_mem_rd = 1'($urandom_range(0, 1));
            id_mem_wr = 1'($urandom_range(0, 1));
            wb_reg_wr = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            flush = ($urandom_range(0, 7) == 0); hold = ($urandom_range(0, 7) == 0);
            tick();
        end
        clear_inputs();

        // Reset during hold with a flush pending
        hold = 1; flush = 1;
        tick();
        flush = 0; rst = 1;
        tick();
        check("t6_reset_valid", BW'(ex_valid), 0);
        check("t6_reset_bundle", dut_bundle(), 0);
        check("t6_reset_stall_count", BW'(stall_count), 0);
        check("t6_reset_flush_count", BW'(flush_count), 0);
        rst = 0; hold = 0;
        set_id(5'd1, 5'd2, 5'd15, 1, 1, 32'h1, 32'h2, 0);
        tick();
        check("t6_post_reset_valid", BW'(ex_valid), 1);
        check("t6_post_reset_rd", BW'(ex_rd), 15);
        check("t6_post_reset_flush_count", BW'(flush_count), 0);

        // Counter saturation at 4 bits
        for (int i = 0; i < 17; i++) begin
            set_id(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 1);
            tick();
            set_id(5'd5, 5'd0, 5'd6, 1, 0, 32'h5, 32'h0, 0);
            tick();
        end
        check("t6_stall_sat", BW'(stall_count), 15);
        for (int i = 0; i < 17; i++) begin
            flush = 1;
            tick();
        end
        flush = 0;
        check("t6_flush_sat", BW'(flush_count), 15);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
